// File: rtl/apb_master.sv
// Single-transfer APB requester: turns a local command into an APB SETUP/ACCESS
// sequence toward two slaves, with a bounded wait for pready and a timeout response.
module apb_master #(
   parameter int unsigned TIMEOUT = 16
) (
   input  logic       pclk,
   input  logic       preset,
   input  logic       req,
   input  logic       req_write,
   input  logic [8:0] req_addr,
   input  logic [7:0] req_wdata,
   output logic       req_ready,
   output logic       psel1,
   output logic       psel2,
   output logic       penable,
   output logic       pwrite,
   output logic [7:0] paddr,
   output logic [7:0] pwdata,
   input  logic       pready1,
   input  logic       pready2,
   input  logic [7:0] prdata1,
   input  logic [7:0] prdata2,
   output logic       rsp_valid,
   output logic [7:0] rsp_rdata,
   output logic       rsp_err
);

   localparam int unsigned CW = $clog2(TIMEOUT + 1);

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      SETUP  = 2'd1,
      ACCESS = 2'd2
   } state_t;

   state_t          state_q;
   logic [CW-1:0]   cnt_q;
   logic            psel1_q;
   logic            psel2_q;
   logic            penable_q;
   logic            pwrite_q;
   logic [7:0]      paddr_q;
   logic [7:0]      pwdata_q;
   logic            rsp_valid_q;
   logic [7:0]      rsp_rdata_q;
   logic            rsp_err_q;
   logic            pready_d;
   logic [7:0]      prdata_d;

   // Only the slave that owns the current transfer is listened to.
   always_comb begin
      pready_d = 1'b0;
      prdata_d = 8'h00;
      if (psel2_q) begin
         pready_d = pready2;
         prdata_d = prdata2;
      end else begin
         pready_d = pready1;
         prdata_d = prdata1;
      end
   end

   // Transfer sequencer with all bus and response outputs held in registers.
   always_ff @(posedge pclk) begin
      if (!preset) begin
         state_q     <= IDLE;
         cnt_q       <= '0;
         psel1_q     <= 1'b0;
         psel2_q     <= 1'b0;
         penable_q   <= 1'b0;
         pwrite_q    <= 1'b0;
         paddr_q     <= 8'h00;
         pwdata_q    <= 8'h00;
         rsp_valid_q <= 1'b0;
         rsp_rdata_q <= 8'h00;
         rsp_err_q   <= 1'b0;
      end else begin
         rsp_valid_q <= 1'b0;
         case (state_q)
            IDLE: begin
               if (req) begin
                  pwrite_q <= req_write;
                  paddr_q  <= req_addr[7:0];
                  pwdata_q <= req_wdata;
                  psel1_q  <= ~req_addr[8];
                  psel2_q  <= req_addr[8];
                  state_q  <= SETUP;
               end
            end
            SETUP: begin
               penable_q <= 1'b1;
               cnt_q     <= '0;
               state_q   <= ACCESS;
            end
            ACCESS: begin
               if (pready_d) begin
                  rsp_valid_q <= 1'b1;
                  rsp_err_q   <= 1'b0;
                  rsp_rdata_q <= pwrite_q ? 8'h00 : prdata_d;
                  psel1_q     <= 1'b0;
                  psel2_q     <= 1'b0;
                  penable_q   <= 1'b0;
                  state_q     <= IDLE;
               end else if (cnt_q == CW'(TIMEOUT - 1)) begin
                  // This edge completes the TIMEOUT-th waiting ACCESS cycle.
                  rsp_valid_q <= 1'b1;
                  rsp_err_q   <= 1'b1;
                  rsp_rdata_q <= 8'h00;
                  psel1_q     <= 1'b0;
                  psel2_q     <= 1'b0;
                  penable_q   <= 1'b0;
                  state_q     <= IDLE;
               end else begin
                  cnt_q <= cnt_q + CW'(1);
               end
            end
            default: begin
               psel1_q   <= 1'b0;
               psel2_q   <= 1'b0;
               penable_q <= 1'b0;
               state_q   <= IDLE;
            end
         endcase
      end
   end

   assign req_ready = (state_q == IDLE);
   assign psel1     = psel1_q;
   assign psel2     = psel2_q;
   assign penable   = penable_q;
   assign pwrite    = pwrite_q;
   assign paddr     = paddr_q;
   assign pwdata    = pwdata_q;
   assign rsp_valid = rsp_valid_q;
   assign rsp_rdata = rsp_rdata_q;
   assign rsp_err   = rsp_err_q;

endmodule

// File: tb/tb_apb_master.sv
// Directed bench for apb_master: two registered-pready slave models, a bus monitor
// and a response scoreboard queue.
module tb_apb_master;

   logic       pclk = 1'b0;
   logic       preset = 1'b0;
   logic       req = 1'b0;
   logic       req_write = 1'b0;
   logic [8:0] req_addr = 9'h000;
   logic [7:0] req_wdata = 8'h00;
   logic       req_ready;
   logic       psel1, psel2, penable, pwrite;
   logic [7:0] paddr, pwdata;
   logic       pready1, pready2;
   logic [7:0] prdata1, prdata2;
   logic       rsp_valid;
   logic [7:0] rsp_rdata;
   logic       rsp_err;

   int total = 0;
   int bad = 0;

   apb_master #(.TIMEOUT(16)) dut (
      .pclk(pclk), .preset(preset), .req(req), .req_write(req_write),
      .req_addr(req_addr), .req_wdata(req_wdata), .req_ready(req_ready),
      .psel1(psel1), .psel2(psel2), .penable(penable), .pwrite(pwrite),
      .paddr(paddr), .pwdata(pwdata), .pready1(pready1), .pready2(pready2),
      .prdata1(prdata1), .prdata2(prdata2), .rsp_valid(rsp_valid),
      .rsp_rdata(rsp_rdata), .rsp_err(rsp_err)
   );

   always #5 pclk = ~pclk;

   // Slaves: pready registered from psel&&penable, so it lingers one cycle past a transfer.
   logic [7:0] mem1 [256];
   logic [7:0] mem2 [256];
   logic       pr1_q, pr2_q;
   logic       tie1 = 1'b0;
   always @(posedge pclk) begin
      pr1_q <= psel1 && penable && !tie1;
      pr2_q <= psel2 && penable;
      if (psel1 && penable && pready1 && pwrite) mem1[paddr] <= pwdata;
      if (psel2 && penable && pready2 && pwrite) mem2[paddr] <= pwdata;
   end
   assign pready1 = pr1_q;
   assign pready2 = pr2_q;
   assign prdata1 = mem1[paddr];
   assign prdata2 = mem2[paddr];

   // Free-running bus monitor; tasks take deltas of these counters.
   int n_psel1 = 0, n_psel2 = 0, n_pen = 0, n_both = 0, n_rsp = 0, n_chg = 0;
   logic       prev_sel, prev_wr, prev_s2;
   logic [7:0] prev_addr, prev_wdata, mon_addr, mon_wdata;
   logic       mon_wr;
   always @(negedge pclk) begin
      if (psel1) n_psel1 <= n_psel1 + 1;
      if (psel2) n_psel2 <= n_psel2 + 1;
      if (penable) n_pen <= n_pen + 1;
      if (psel1 && psel2) n_both <= n_both + 1;
      if (rsp_valid) n_rsp <= n_rsp + 1;
      if ((psel1 || psel2) && prev_sel &&
          (paddr !== prev_addr || pwdata !== prev_wdata || pwrite !== prev_wr || psel2 !== prev_s2))
         n_chg <= n_chg + 1;
      if (psel1 || psel2) begin
         mon_addr  <= paddr;
         mon_wdata <= pwdata;
         mon_wr    <= pwrite;
      end
      prev_sel   <= psel1 || psel2;
      prev_addr  <= paddr;
      prev_wdata <= pwdata;
      prev_wr    <= pwrite;
      prev_s2    <= psel2;
   end

   logic [8:0] exp_q [$];

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge pclk);
      #1;
   endtask

   task automatic wait_ready(input string tag);
      int n = 0;
      @(negedge pclk);
      while (!req_ready && n < 50) begin
         @(negedge pclk);
         n++;
      end
      check({tag, "_ready"}, req_ready, 1'b1);
   endtask

   task automatic wait_rsp(input string tag);
      int n = 0;
      @(negedge pclk);
      while (rsp_valid !== 1'b1 && n < 300) begin
         @(negedge pclk);
         n++;
      end
      check({tag, "_rsp_seen"}, rsp_valid, 1'b1);
   endtask

   task automatic pop_check(input string tag);
      logic [8:0] e;
      e = (exp_q.size() > 0) ? exp_q.pop_front() : 9'h1FF;
      check({tag, "_rdata"}, rsp_rdata, e[7:0]);
      check({tag, "_err"}, rsp_err, e[8]);
   endtask

   task automatic xfer(input logic w, input logic [8:0] a, input logic [7:0] d,
                       input logic [7:0] exp_rd, input logic exp_err, input int exp_pen,
                       input string tag);
      int s1, s2, sp, sb, sr, sc;
      exp_q.push_back({exp_err, exp_rd});
      s1 = n_psel1; s2 = n_psel2; sp = n_pen; sb = n_both; sr = n_rsp; sc = n_chg;
      req = 1'b1; req_write = w; req_addr = a; req_wdata = d;
      wait_ready(tag);
      tick();
      req = 1'b0;
      wait_rsp(tag);
      pop_check(tag);
      tick();
      check({tag, "_pulse"}, rsp_valid, 1'b0);
      check({tag, "_psel1_cyc"}, n_psel1 - s1, a[8] ? 0 : exp_pen + 1);
      check({tag, "_psel2_cyc"}, n_psel2 - s2, a[8] ? exp_pen + 1 : 0);
      check({tag, "_pen_cyc"}, n_pen - sp, exp_pen);
      check({tag, "_both_sel"}, n_both - sb, 0);
      check({tag, "_rsp_cnt"}, n_rsp - sr, 1);
      check({tag, "_stable"}, n_chg - sc, 0);
      check({tag, "_paddr"}, mon_addr, a[7:0]);
      check({tag, "_pwrite"}, mon_wr, w);
      if (w) check({tag, "_pwdata"}, mon_wdata, d);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog expired observed=running expected=finished");
      $fatal(1, "watchdog");
   end

   initial begin
      int sp, s1, sr;
      preset = 1'b0;
      repeat (3) tick();
      check("rst_ready", req_ready, 1'b1);
      check("rst_psel", {psel1, psel2, penable, pwrite}, 4'b0000);
      check("rst_rsp", {rsp_valid, rsp_err, rsp_rdata}, 10'h000);
      check("rst_bus", {paddr, pwdata}, 16'h0000);
      preset = 1'b1;
      tick();

      xfer(1'b1, 9'h03C, 8'hA5, 8'h00, 1'b0, 2, "wr1");
      check("mem1_3c", mem1[8'h3C], 8'hA5);
      xfer(1'b0, 9'h03C, 8'h00, 8'hA5, 1'b0, 2, "rd1");
      tick(); tick();
      check("rdata_hold", rsp_rdata, 8'hA5);

      xfer(1'b1, 9'h010, 8'h77, 8'h00, 1'b0, 2, "wr1_10");
      xfer(1'b1, 9'h110, 8'h5A, 8'h00, 1'b0, 2, "wr2");
      xfer(1'b0, 9'h110, 8'h00, 8'h5A, 1'b0, 2, "rd2");
      check("mem2_10", mem2[8'h10], 8'h5A);
      check("mem1_10_kept", mem1[8'h10], 8'h77);
      xfer(1'b0, 9'h010, 8'h00, 8'h77, 1'b0, 2, "rd1_10");

      tie1 = 1'b1;
      xfer(1'b0, 9'h001, 8'h00, 8'h00, 1'b1, 16, "tmo");
      check("tmo_idle", req_ready, 1'b1);
      tie1 = 1'b0;

      // Reset while waiting in ACCESS: command must vanish without a response.
      tie1 = 1'b1;
      sr = n_rsp;
      req = 1'b1; req_write = 1'b0; req_addr = 9'h005;
      wait_ready("rstx");
      tick();
      req = 1'b0;
      repeat (4) tick();
      check("rstx_in_access", {psel1, penable}, 2'b11);
      preset = 1'b0;
      tick();
      check("rstx_bus", {psel1, psel2, penable, rsp_valid}, 4'b0000);
      check("rstx_rdata", rsp_rdata, 8'h00);
      check("rstx_paddr", paddr, 8'h00);
      check("rstx_ready", req_ready, 1'b1);
      tick();
      preset = 1'b1;
      tie1 = 1'b0;
      repeat (4) tick();
      check("rstx_no_rsp", n_rsp - sr, 0);
      xfer(1'b1, 9'h020, 8'h99, 8'h00, 1'b0, 2, "post_rst_wr");
      xfer(1'b0, 9'h020, 8'h00, 8'h99, 1'b0, 2, "post_rst_rd");

      // Back-to-back writes with req held high throughout.
      exp_q.push_back({1'b0, 8'h00});
      exp_q.push_back({1'b0, 8'h00});
      req = 1'b1; req_write = 1'b1; req_addr = 9'h001; req_wdata = 8'h11;
      wait_ready("b2b_a");
      tick();
      req_addr = 9'h002; req_wdata = 8'h22;
      wait_rsp("b2b_a");
      pop_check("b2b_a");
      check("b2b_ready_back", req_ready, 1'b1);
      tick();
      req = 1'b0;
      sp = n_pen; s1 = n_psel1;
      @(negedge pclk);
      check("b2b_setup", {psel1, penable}, 2'b10);
      wait_rsp("b2b_b");
      pop_check("b2b_b");
      tick();
      check("b2b_pen_cyc", n_pen - sp, 2);
      check("b2b_psel_cyc", n_psel1 - s1, 3);
      check("b2b_mem1", mem1[8'h01], 8'h11);
      check("b2b_mem2", mem1[8'h02], 8'h22);
      xfer(1'b0, 9'h001, 8'h00, 8'h11, 1'b0, 2, "b2b_rd1");
      xfer(1'b0, 9'h002, 8'h00, 8'h22, 1'b0, 2, "b2b_rd2");
      check("queue_empty", exp_q.size(), 0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/apb_master.md
# apb_master

Single-transfer APB requester that turns a simple local command (address, write flag, write data) into a full APB SETUP/ACCESS sequence toward two 8-bit-address slaves. It decodes slave select from an address extension bit, holds the bus stable through wait states, and returns read data, or a timeout error, on a one-cycle response strobe. It sits between the local controller and the APB slaves; it is the initiator end of the slave-side interface.

## Interface
- TIMEOUT, 16: max ACCESS cycles waiting for pready before abort; legal range 2..255
- pclk  in  1  bus clock; all logic on rising edge
- preset  in  1  reset, synchronous, active-low
- req  in  1  command valid; accepted on an edge where req && req_ready
- req_write  in  1  1 = write, 0 = read
- req_addr  in  9  bit 8 selects slave (0 = slave 1, 1 = slave 2); bits 7:0 drive paddr
- req_wdata  in  8  write data
- req_ready  out  1  high only in IDLE
- psel1  out  1  select, slave 1
- psel2  out  1  select, slave 2
- penable  out  1  APB enable
- pwrite  out  1  APB direction
- paddr  out  8  APB address
- pwdata  out  8  APB write data
- pready1, pready2  in  1  ready from slave 1 / slave 2
- prdata1, prdata2  in  8  read data from slave 1 / slave 2
- rsp_valid  out  1  one-cycle pulse: transfer finished
- rsp_rdata  out  8  read data; valid with rsp_valid
- rsp_err  out  1  timeout flag; valid with rsp_valid

## Operation
- FSM states: IDLE, SETUP, ACCESS. Reset → IDLE.
- IDLE: req_ready=1, psel1/psel2/penable=0. On accept: latch req fields, drive pwrite/paddr/pwdata, assert selected psel, go to SETUP.
- SETUP: penable=0, one cycle; unconditionally → ACCESS, penable=1, timeout counter cleared to 0.
- ACCESS: pready/prdata of the selected slave only. pready=1 → capture prdata (reads only; writes load rsp_rdata=0x00), rsp_err=0, pulse rsp_valid, drop psel and penable, → IDLE. pready=0 → counter+1; when the counter reaches TIMEOUT → abort: rsp_valid=1, rsp_err=1, rsp_rdata=0x00, drop psel and penable, → IDLE.
- pwrite, paddr, pwdata, and the selected psel stay constant from SETUP through the last ACCESS cycle. In IDLE, pwrite/paddr/pwdata hold their last values.
- Never assert psel1 and psel2 together.
- pready is ignored outside ACCESS. Slaves may hold a stale pready one cycle past the transfer.
- Counter width is clog2(TIMEOUT+1); it must not wrap.
- Reset values: state IDLE; psel1, psel2, penable, pwrite, rsp_valid, rsp_err = 0; paddr, pwdata, rsp_rdata = 0x00; req_ready = 1 from the first cycle after reset.
- Reset mid-transfer: on the next edge, all outputs take their reset values. No rsp_valid is produced. The command is dropped.

## Timing
- All outputs are registered except req_ready, which is decoded from state.
- Accept at edge N: after N, SETUP (psel=1, penable=0). After N+1, ACCESS (penable=1).
- A slave that registers pready one cycle after psel&&penable gives pready=1 after N+2. The master samples it at N+3. After N+3: rsp_valid=1, psel/penable=0, IDLE.
- Zero-wait transfer: psel high 3 cycles, penable high 2 cycles, rsp_valid 1 cycle. Next accept no earlier than edge N+4.
- rsp_valid lasts exactly one cycle. rsp_rdata and rsp_err hold until the next response.
- Timeout: abort takes effect TIMEOUT ACCESS cycles after entering ACCESS with pready continuously low.

## Test plan
- Write: req_addr=0x03C, wdata=0xA5 → psel1 high 3 cycles, psel2=0, penable high 2 cycles, paddr=0x3C, pwdata=0xA5, then rsp_valid=1, rsp_err=0; slave 1 mem[0x3C]=0xA5.
- Read-back: read req_addr=0x03C → rsp_rdata=0xA5 with rsp_valid, rsp_err=0.
- Slave 2: write 0x110, data 0x5A, then read 0x110 → only psel2 asserts, paddr=0x10, rsp_rdata=0x5A; slave 1 contents unchanged.
- Timeout: TIMEOUT=16, pready1 tied low, read 0x001 → penable high exactly 16 cycles, then rsp_valid=1, rsp_err=1, rsp_rdata=0x00, FSM returns to IDLE.
- Reset in ACCESS: drop preset during a wait state → next cycle psel1=penable=0, no rsp_valid; after release, req_ready=1 and a new write completes normally.
- Back-to-back: req held high with two writes (0x001→0x11, 0x002→0x22) → second accepted the cycle req_ready returns; stale pready from the first transfer does not shorten the second ACCESS; both locations are correct on read-back.
